// File: rtl/psum_ofifo_pkg.sv
// Shared constants and types for the psum output FIFO.
package psum_ofifo_pkg;

  localparam int PSUM_BW = 16;
  localparam int COL     = 8;
  localparam int DEPTH   = 16;
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;

  typedef logic [PSUM_BW-1:0] psum_t;

endpackage

// File: rtl/psum_ofifo_lane.sv
// One lane of the psum output FIFO: storage, wrapping pointers, occupancy count.
// The head entry is presented combinationally (first-word-fall-through).
module psum_fifo_lane
  import psum_ofifo_pkg::*;
#(
  parameter int w     = PSUM_BW,
  parameter int depth = DEPTH
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr,
  input  logic         pop,
  input  logic [w-1:0] din,
  output logic [w-1:0] dout,
  output logic         empty,
  output logic         full
);

  localparam int PW = $clog2(depth);
  localparam int CW = PW + 1;

  logic [w-1:0]  mem [depth];
  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] cnt;
  logic          wr_ok;

  assign empty = (cnt == '0);
  assign full  = (cnt == CW'(depth));
  // A full lane still takes a write when the row pop frees a slot in the same cycle.
  assign wr_ok = wr & (~full | pop);
  assign dout  = mem[rptr];

  // Pointer and occupancy update; pop is only ever asserted on a non-empty lane.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + 1'b1;
      if (pop)   rptr <= rptr + 1'b1;
      case ({wr_ok, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage write; contents are not cleared by reset, and a write during reset is discarded.
  always_ff @(posedge clk) begin
    if (wr_ok && !reset) mem[wptr] <= din;
  end

endmodule

// File: rtl/psum_ofifo.sv
// Per-column output FIFO: col independent lanes, presented and popped as whole rows.
// Optional sticky error flags o_err (overflow/underflow) when PSUM_OFIFO_ERR_EN is defined.
module psum_ofifo
  import psum_ofifo_pkg::*;
#(
  parameter int psum_bw = PSUM_BW,
  parameter int col     = COL,
  parameter int depth   = DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [col-1:0]         wr,
  input  logic [psum_bw*col-1:0] in,
  input  logic                   rd,
  output logic [psum_bw*col-1:0] out,
  output logic                   o_valid,
  output logic                   o_full,
  output logic                   o_ready
`ifdef PSUM_OFIFO_ERR_EN
  ,
  output logic [1:0]             o_err
`endif
);

  logic [col-1:0][psum_bw-1:0] din_a, dout_a;
  logic [col-1:0]              empty, full;
  logic                        pop;

  assign din_a = in;

  for (genvar g = 0; g < col; g++) begin : g_lane
    psum_fifo_lane #(.w(psum_bw), .depth(depth)) u_lane (
      .clk  (clk),
      .reset(reset),
      .wr   (wr[g]),
      .pop  (pop),
      .din  (din_a[g]),
      .dout (dout_a[g]),
      .empty(empty[g]),
      .full (full[g])
    );
  end

  // Flags come only from registered lane counts, never from wr/rd.
  assign o_valid = &(~empty);
  assign o_full  = |full;
  assign o_ready = ~o_full;
  assign pop     = rd & o_valid;
  assign out     = o_valid ? dout_a : '0;

`ifdef PSUM_OFIFO_ERR_EN
  // Sticky overflow (dropped write) and underflow (read with no full row).
  always_ff @(posedge clk) begin
    if (reset) begin
      o_err <= '0;
    end else begin
      if (|(wr & full) && !pop) o_err[0] <= 1'b1;
      if (rd && !o_valid)       o_err[1] <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_psum_ofifo.sv
// Self-checking bench for psum_ofifo: vector table plus per-lane queue scoreboard.
module tb_psum_ofifo;
  import psum_ofifo_pkg::*;

  localparam int C = COL;
  localparam int W = PSUM_BW;
  localparam int D = DEPTH;
  typedef logic [C-1:0][W-1:0] row_t;

  logic         clk = 1'b0;
  logic         reset;
  logic [C-1:0] wr;
  row_t         in;
  logic         rd;
  row_t         out;
  logic         o_valid, o_full, o_ready;
`ifdef PSUM_OFIFO_ERR_EN
  logic [1:0]   o_err;
`endif

  always #5 clk = ~clk;

  psum_ofifo dut (
    .clk    (clk),
    .reset  (reset),
    .wr     (wr),
    .in     (in),
    .rd     (rd),
    .out    (out),
    .o_valid(o_valid),
    .o_full (o_full),
    .o_ready(o_ready)
`ifdef PSUM_OFIFO_ERR_EN
    ,
    .o_err  (o_err)
`endif
  );

  logic [W-1:0] mq [C][$];
  logic [1:0]   merr;
  int           errors = 0;
  int           checks = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit mvalid();
    bit v = 1'b1;
    for (int i = 0; i < C; i++) if (mq[i].size() == 0) v = 1'b0;
    return v;
  endfunction

  function automatic bit mfull();
    bit f = 1'b0;
    for (int i = 0; i < C; i++) if (mq[i].size() == D) f = 1'b1;
    return f;
  endfunction

  function automatic row_t mhead();
    row_t e = '0;
    if (mvalid()) for (int i = 0; i < C; i++) e[i] = mq[i][0];
    return e;
  endfunction

  function automatic row_t mk(input int base);
    row_t d;
    for (int i = 0; i < C; i++) d[i] = W'(base + i);
    return d;
  endfunction

  task automatic check_outputs();
    chk("o_valid", 256'(o_valid), 256'(mvalid()));
    chk("o_full",  256'(o_full),  256'(mfull()));
    chk("o_ready", 256'(o_ready), 256'(!mfull()));
    chk("out",     256'(out),     256'(mhead()));
`ifdef PSUM_OFIFO_ERR_EN
    chk("o_err",   256'(o_err),   256'(merr));
`endif
  endtask

  // Called on a falling edge: update the model, drive inputs, then check after the next rising edge.
  task automatic drive(input bit r, input logic [C-1:0] w, input row_t d, input bit rdv);
    bit mv = mvalid();
    if (r) begin
      for (int i = 0; i < C; i++) mq[i].delete();
      merr = '0;
    end else begin
      if (rdv && !mv) merr[1] = 1'b1;
      if (rdv && mv) begin
        chk("pop_row", 256'(out), 256'(mhead()));
        for (int i = 0; i < C; i++) void'(mq[i].pop_front());
      end
      for (int i = 0; i < C; i++)
        if (w[i]) begin
          if (mq[i].size() < D) mq[i].push_back(d[i]);
          else merr[0] = 1'b1;
        end
    end
    reset = r; wr = w; in = d; rd = rdv;
    @(negedge clk);
    reset = 1'b0; wr = '0; rd = 1'b0;
    check_outputs();
  endtask

  typedef struct {
    bit           rst;
    logic [C-1:0] wr;
    int           base;
    bit           rd;
    bit           ev;
    bit           ef;
    logic [W-1:0] e0;
  } vec_t;

  vec_t tbl [7];

  initial begin
    reset = 1'b1; wr = '0; rd = 1'b0; in = '0; merr = '0;
    @(negedge clk);

    //                rst  wr     base rd  valid full lane0
    tbl[0] = '{1'b1, 8'h00,   0, 1'b0, 1'b0, 1'b0,  16'd0};
    tbl[1] = '{1'b0, 8'h00,   0, 1'b0, 1'b0, 1'b0,  16'd0};
    tbl[2] = '{1'b0, 8'hFF,   1, 1'b0, 1'b1, 1'b0,  16'd1};
    tbl[3] = '{1'b0, 8'h00,   0, 1'b1, 1'b0, 1'b0,  16'd0};
    tbl[4] = '{1'b0, 8'h00,   0, 1'b1, 1'b0, 1'b0,  16'd0};
    tbl[5] = '{1'b0, 8'hFF, 100, 1'b1, 1'b1, 1'b0, 16'd100};
    tbl[6] = '{1'b0, 8'h00,   0, 1'b1, 1'b0, 1'b0,  16'd0};
    for (int k = 0; k < 7; k++) begin
      drive(tbl[k].rst, tbl[k].wr, mk(tbl[k].base), tbl[k].rd);
      chk($sformatf("tbl%0d_valid", k), 256'(o_valid), 256'(tbl[k].ev));
      chk($sformatf("tbl%0d_full", k),  256'(o_full),  256'(tbl[k].ef));
      chk($sformatf("tbl%0d_out0", k),  256'(out[0]),  256'(tbl[k].e0));
    end
    chk("tbl2_out7_seen", 256'(mq[0].size()), 256'(0));

    // Skewed arrival: lane 0 runs ahead by two entries.
    drive(0, 8'h01, mk(10), 0);
    drive(0, 8'h01, mk(11), 0);
    drive(0, 8'h01, mk(12), 0);
    for (int i = 1; i < C; i++) begin
      chk($sformatf("skew_before_lane%0d", i), 256'(o_valid), 256'(0));
      drive(0, C'(1) << i, mk(20), 0);
    end
    chk("skew_valid", 256'(o_valid), 256'(1));
    chk("skew_lane0", 256'(out[0]), 256'(10));
    chk("skew_lane7", 256'(out[7]), 256'(27));
    drive(0, '0, mk(0), 1);
    chk("skew_after_pop", 256'(o_valid), 256'(0));
    drive(0, 8'hFE, mk(30), 0);
    chk("skew_lane0_11", 256'(out[0]), 256'(11));
    drive(0, 8'hFE, mk(40), 0);
    drive(0, '0, mk(0), 1);
    drive(0, '0, mk(0), 1);
    chk("skew_drained", 256'(o_valid), 256'(0));

    // Fill lane 3, overflow it, then write+pop on the full lane.
    for (int k = 0; k < D; k++) drive(0, 8'h08, mk(40 + k), 0);
    chk("fill_full",  256'(o_full),  256'(1));
    chk("fill_ready", 256'(o_ready), 256'(0));
    drive(0, 8'h08, mk(999), 0);
    chk("drop_full", 256'(o_full), 256'(1));
`ifdef PSUM_OFIFO_ERR_EN
    chk("drop_err0", 256'(o_err[0]), 256'(1));
`endif
    drive(0, 8'hF7, mk(200), 0);
    chk("full_row_valid", 256'(o_valid), 256'(1));
    chk("full_row_lane3", 256'(out[3]), 256'(43));
    drive(0, 8'h08, mk(500), 1);
    chk("wrpop_full", 256'(o_full), 256'(1));
    chk("wrpop_lane3_size", 256'(mq[3].size()), 256'(D));
    drive(1, '0, mk(0), 0);
    chk("rst_clear_full", 256'(o_full), 256'(0));

    // Streaming rows across pointer wrap.
    for (int r = 0; r < 10; r++) drive(0, '1, mk(r * 8), 0);
    for (int r = 10; r < 40; r++) drive(0, '1, mk(r * 8), 1);
    for (int r = 0; r < 10; r++) drive(0, '0, mk(0), 1);
    chk("stream_drained", 256'(o_valid), 256'(0));

    // Reset mid-stream with rd and wr asserted.
    for (int r = 0; r < 5; r++) drive(0, '1, mk(600 + r * 8), 0);
    drive(1, '1, mk(77), 1);
    chk("midrst_valid", 256'(o_valid), 256'(0));
    chk("midrst_out",   256'(out),     256'(0));
    drive(0, '1, mk(300), 0);
    chk("midrst_fresh_lane0", 256'(out[0]), 256'(300));
    drive(0, '0, mk(0), 1);
    chk("midrst_empty", 256'(o_valid), 256'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
